// File: rtl/useq_pkg.sv
// Shared types for the microprogrammed sequencer: sequencing ops, RV32 opcode
// classes and the instruction-to-dispatch-address decoder.
package useq_pkg;

  typedef enum logic [2:0] {
    DISPATCH = 3'b000,
    JUMP     = 3'b001,
    BRANCH   = 3'b010,
    WAIT     = 3'b011,
    LOOP     = 3'b100
  } seq_op_e;

  typedef enum logic {
    ST_DISP = 1'b0,
    ST_SEQ  = 1'b1
  } useq_state_e;

  // opcode[6:2] classes
  localparam logic [4:0] TYPE_R      = 5'b01100;
  localparam logic [4:0] TYPE_I_COMP = 5'b00100;
  localparam logic [4:0] TYPE_I_LOAD = 5'b00000;
  localparam logic [4:0] TYPE_I_JALR = 5'b11001;
  localparam logic [4:0] TYPE_S      = 5'b01000;
  localparam logic [4:0] TYPE_SB     = 5'b11000;

  function automatic logic [8:0] dispatch_addr(input logic [31:0] instr);
    logic [4:0] opc;
    logic [2:0] f3;
    logic       use_f3;
    logic       use_b30;
    opc     = instr[6:2];
    f3      = instr[14:12];
    use_f3  = (opc == TYPE_R) || (opc == TYPE_I_COMP) || (opc == TYPE_I_LOAD) ||
              (opc == TYPE_I_JALR) || (opc == TYPE_S) || (opc == TYPE_SB);
    // bit 30 separates add/sub and srl/sra
    use_b30 = (opc == TYPE_R) || ((opc == TYPE_I_COMP) && (f3 == 3'b101));
    return {opc, (use_f3 ? f3 : 3'b000), (use_b30 ? instr[30] : 1'b0)};
  endfunction

endpackage

// File: rtl/useq_store.sv
// Writable control store: register array with one combinational read port, one
// write port and a per-entry valid bit. Reads see the pre-edge contents.
module useq_store #(
  parameter int DATA_W = 34,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  vld;

  // data is deliberately not reset; only the valid bits are
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     vld        <= '0;
    else if (we) vld[waddr] <= 1'b1;
  end

  assign rdata  = mem[raddr];
  assign rvalid = vld[raddr];

endmodule

// File: rtl/useq_controller.sv
// Microprogrammed sequencer: decodes the instruction into a dispatch address,
// then steps through control-store microprograms with jump/branch/wait/loop.
module useq_controller
  import useq_pkg::*;
#(
  parameter int CTRL_SIZE = 21,
  parameter int ADDR_W    = 9,
  parameter int N_COND    = 2,
  parameter int LOOP_W    = 8,
  localparam int CS_W     = (N_COND > 1) ? $clog2(N_COND) : 1,
  localparam int W_C      = CTRL_SIZE + 3 + CS_W + ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instruction,
  input  logic                 instr_valid,
  input  logic                 stall,
  input  logic [N_COND-1:0]    cond,
  input  logic [LOOP_W-1:0]    cnt_load,
  input  logic                 ucode_we,
  input  logic [ADDR_W-1:0]    ucode_waddr,
  input  logic [W_C-1:0]       ucode_wdata,
  output logic [CTRL_SIZE-1:0] ctrl_signals,
  output logic                 busy,
  output logic [ADDR_W-1:0]    upc,
  output logic                 illegal
);

  useq_state_e       state, state_nxt;
  logic [ADDR_W-1:0] upc_r, upc_nxt;
  logic [LOOP_W-1:0] cnt_r, cnt_nxt, cnt_eff;

  logic [ADDR_W-1:0] disp_addr, raddr;
  logic [W_C-1:0]    entry;
  logic              entry_vld;

  logic [CTRL_SIZE-1:0] e_ctrl;
  logic [2:0]           e_op;
  logic [CS_W-1:0]      e_cs;
  logic [ADDR_W-1:0]    e_next;

  logic in_disp, reached, active, cond_hit, go;

  assign disp_addr = ADDR_W'(dispatch_addr(instruction));
  assign in_disp   = (state == ST_DISP);
  assign raddr     = in_disp ? disp_addr : upc_r;

  useq_store #(
    .DATA_W(W_C),
    .ADDR_W(ADDR_W)
  ) u_store (
    .clk   (clk),
    .rst   (rst),
    .we    (ucode_we),
    .waddr (ucode_waddr),
    .wdata (ucode_wdata),
    .raddr (raddr),
    .rdata (entry),
    .rvalid(entry_vld)
  );

  assign e_ctrl = entry[W_C-1 -: CTRL_SIZE];
  assign e_op   = entry[CS_W+ADDR_W +: 3];
  assign e_cs   = entry[ADDR_W +: CS_W];
  assign e_next = entry[ADDR_W-1:0];

  // a DISP cycle without a real instruction is a bubble, not a store access
  assign reached = !in_disp || (instr_valid && (instruction != 32'd0));
  assign active  = reached && entry_vld;
  assign cnt_eff = in_disp ? cnt_load : cnt_r;

  always_comb begin
    cond_hit = 1'b0;
    for (int i = 0; i < N_COND; i++) begin
      if (e_cs == CS_W'(i)) cond_hit = cond[i];
    end
  end

  always_comb begin
    state_nxt = ST_DISP;
    upc_nxt   = upc_r;
    cnt_nxt   = cnt_r;
    go        = 1'b0;
    illegal   = reached && !entry_vld;
    if (active) begin
      if (in_disp) cnt_nxt = cnt_load;
      case (e_op)
        DISPATCH: ;
        JUMP:     go = 1'b1;
        BRANCH:   go = cond_hit;
        WAIT: begin
          if (cond_hit) begin
            go = 1'b1;
          end else begin
            state_nxt = ST_SEQ;
            upc_nxt   = raddr;
          end
        end
        LOOP: begin
          if (cnt_eff != '0) begin
            cnt_nxt = cnt_eff - LOOP_W'(1);
            go      = 1'b1;
          end
        end
        default:  illegal = 1'b1;
      endcase
      if (go) begin
        state_nxt = ST_SEQ;
        upc_nxt   = e_next;
      end
    end
  end

  assign busy         = (state_nxt == ST_SEQ) || (stall && !in_disp);
  assign ctrl_signals = active ? e_ctrl : '0;
  assign upc          = raddr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_DISP;
      upc_r <= '0;
      cnt_r <= '0;
    end else if (!stall) begin
      state <= state_nxt;
      upc_r <= upc_nxt;
      cnt_r <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_useq_controller.sv
// Directed bench for useq_controller: a table of per-cycle vectors plus
// hand-written reset and write-collision sequences.
module tb_useq_controller;
  import useq_pkg::*;

  localparam int CTRL_SIZE = 21;
  localparam int ADDR_W    = 9;
  localparam int N_COND    = 2;
  localparam int LOOP_W    = 8;
  localparam int W_C       = CTRL_SIZE + 3 + 1 + ADDR_W;

  localparam logic [31:0] I_ADD  = 32'h002081B3; // 0x0C0
  localparam logic [31:0] I_SUB  = 32'h402081B3; // 0x0C1
  localparam logic [31:0] I_LW   = 32'h0000A183; // 0x004
  localparam logic [31:0] I_LH   = 32'h00009183; // 0x002
  localparam logic [31:0] I_SW   = 32'h0020A023; // 0x084
  localparam logic [31:0] I_BEQ  = 32'h00208063; // 0x180
  localparam logic [31:0] I_ADDI = 32'h00100093; // 0x040
  localparam logic [31:0] I_SRAI = 32'h4010D093; // 0x04B
  localparam logic [31:0] I_LUI  = 32'h123450B7; // 0x0D0

  logic                 clk = 1'b0;
  logic                 rst;
  logic [31:0]          instruction;
  logic                 instr_valid;
  logic                 stall;
  logic [N_COND-1:0]    cond;
  logic [LOOP_W-1:0]    cnt_load;
  logic                 ucode_we;
  logic [ADDR_W-1:0]    ucode_waddr;
  logic [W_C-1:0]       ucode_wdata;
  logic [CTRL_SIZE-1:0] ctrl_signals;
  logic                 busy;
  logic [ADDR_W-1:0]    upc;
  logic                 illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  useq_controller #(
    .CTRL_SIZE(CTRL_SIZE), .ADDR_W(ADDR_W), .N_COND(N_COND), .LOOP_W(LOOP_W)
  ) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
    .stall(stall), .cond(cond), .cnt_load(cnt_load), .ucode_we(ucode_we),
    .ucode_waddr(ucode_waddr), .ucode_wdata(ucode_wdata),
    .ctrl_signals(ctrl_signals), .busy(busy), .upc(upc), .illegal(illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic        vld;
    logic        stl;
    logic [1:0]  cnd;
    logic [7:0]  cl;
    logic [20:0] ctrl;
    logic        bsy;
    logic [8:0]  upc;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(logic [31:0] instr, logic vld, logic stl, logic [1:0] cnd,
                               logic [7:0] cl, logic [20:0] ctrl, logic bsy,
                               logic [8:0] upc_e, logic ill);
    vec_t v;
    v.instr = instr; v.vld = vld; v.stl = stl; v.cnd = cnd; v.cl = cl;
    v.ctrl = ctrl; v.bsy = bsy; v.upc = upc_e; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [20:0] c, input logic b,
                         input logic [8:0] u, input logic il);
    chk({tag, " ctrl"},    32'(ctrl_signals), 32'(c));
    chk({tag, " busy"},    32'(busy),         32'(b));
    chk({tag, " upc"},     32'(upc),          32'(u));
    chk({tag, " illegal"}, 32'(illegal),      32'(il));
  endtask

  task automatic ld(input logic [8:0] addr, input logic [20:0] c, input logic [2:0] op,
                    input logic cs, input logic [8:0] nxt);
    @(negedge clk);
    ucode_we    = 1'b1;
    ucode_waddr = addr;
    ucode_wdata = {c, op, cs, nxt};
    @(negedge clk);
    ucode_we    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; instruction = '0; instr_valid = 1'b0; stall = 1'b0; cond = '0;
    cnt_load = '0; ucode_we = 1'b0; ucode_waddr = '0; ucode_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 chk_all("reset", 21'h0, 1'b0, 9'h000, 1'b0);

    ld(9'h0C0, 21'h1E0000, DISPATCH, 1'b0, 9'h000);
    ld(9'h004, 21'h000101, JUMP,     1'b0, 9'h005);
    ld(9'h005, 21'h000055, DISPATCH, 1'b0, 9'h000);
    ld(9'h002, 21'h000202, WAIT,     1'b0, 9'h005);
    ld(9'h084, 21'h000A00, JUMP,     1'b0, 9'h100);
    ld(9'h100, 21'h0000F0, LOOP,     1'b0, 9'h100);
    ld(9'h180, 21'h000777, BRANCH,   1'b1, 9'h005);

    //            instr   vld  stl  cnd    cl     ctrl       bsy   upc     ill
    vecs.push_back(mkv(I_ADD,  1, 0, 2'b00, 8'd0, 21'h1E0000, 0, 9'h0C0, 0));
    // lw: JUMP then DISPATCH
    vecs.push_back(mkv(I_LW,   1, 0, 2'b00, 8'd0, 21'h000101, 1, 9'h004, 0));
    vecs.push_back(mkv(I_LW,   1, 0, 2'b00, 8'd0, 21'h000055, 0, 9'h005, 0));
    vecs.push_back(mkv(I_LW,   0, 0, 2'b00, 8'd0, 21'h000000, 0, 9'h004, 0));
    // decode of unwritten entries: funct3, bit 30 and ignored funct3
    vecs.push_back(mkv(I_SUB,  1, 0, 2'b00, 8'd0, 21'h000000, 0, 9'h0C1, 1));
    vecs.push_back(mkv(I_ADDI, 1, 0, 2'b00, 8'd0, 21'h000000, 0, 9'h040, 1));
    vecs.push_back(mkv(I_SRAI, 1, 0, 2'b00, 8'd0, 21'h000000, 0, 9'h04B, 1));
    vecs.push_back(mkv(I_LUI,  1, 0, 2'b00, 8'd0, 21'h000000, 0, 9'h0D0, 1));
    // WAIT on cond[0]; cond[1] high must not release it
    vecs.push_back(mkv(I_LH,   1, 0, 2'b10, 8'd0, 21'h000202, 1, 9'h002, 0));
    vecs.push_back(mkv(I_LH,   1, 0, 2'b10, 8'd0, 21'h000202, 1, 9'h002, 0));
    vecs.push_back(mkv(I_LH,   1, 0, 2'b10, 8'd0, 21'h000202, 1, 9'h002, 0));
    vecs.push_back(mkv(I_LH,   1, 0, 2'b01, 8'd0, 21'h000202, 1, 9'h002, 0));
    vecs.push_back(mkv(I_LH,   1, 0, 2'b00, 8'd0, 21'h000055, 0, 9'h005, 0));
    vecs.push_back(mkv(I_LH,   0, 0, 2'b00, 8'd0, 21'h000000, 0, 9'h002, 0));
    // LOOP count 3: body 4 times; cnt_load changes in SEQ are ignored
    vecs.push_back(mkv(I_SW,   1, 0, 2'b00, 8'd3, 21'h000A00, 1, 9'h084, 0));
    vecs.push_back(mkv(I_SW,   1, 0, 2'b00, 8'd7, 21'h0000F0, 1, 9'h100, 0));
    vecs.push_back(mkv(I_SW,   1, 0, 2'b00, 8'd7, 21'h0000F0, 1, 9'h100, 0));
    vecs.push_back(mkv(I_SW,   1, 0, 2'b00, 8'd7, 21'h0000F0, 1, 9'h100, 0));
    vecs.push_back(mkv(I_SW,   1, 0, 2'b00, 8'd7, 21'h0000F0, 0, 9'h100, 0));
    vecs.push_back(mkv(I_SW,   0, 0, 2'b00, 8'd0, 21'h000000, 0, 9'h084, 0));
    // LOOP count 0: body once
    vecs.push_back(mkv(I_SW,   1, 0, 2'b00, 8'd0, 21'h000A00, 1, 9'h084, 0));
    vecs.push_back(mkv(I_SW,   1, 0, 2'b00, 8'd0, 21'h0000F0, 0, 9'h100, 0));
    vecs.push_back(mkv(I_SW,   0, 0, 2'b00, 8'd0, 21'h000000, 0, 9'h084, 0));
    // stall 2 cycles mid-loop: count held, body still runs 4 unstalled cycles
    vecs.push_back(mkv(I_SW,   1, 0, 2'b00, 8'd3, 21'h000A00, 1, 9'h084, 0));
    vecs.push_back(mkv(I_SW,   1, 0, 2'b00, 8'd0, 21'h0000F0, 1, 9'h100, 0));
    vecs.push_back(mkv(I_SW,   1, 1, 2'b00, 8'd0, 21'h0000F0, 1, 9'h100, 0));
    vecs.push_back(mkv(I_SW,   1, 1, 2'b00, 8'd0, 21'h0000F0, 1, 9'h100, 0));
    vecs.push_back(mkv(I_SW,   1, 0, 2'b00, 8'd0, 21'h0000F0, 1, 9'h100, 0));
    vecs.push_back(mkv(I_SW,   1, 0, 2'b00, 8'd0, 21'h0000F0, 1, 9'h100, 0));
    vecs.push_back(mkv(I_SW,   1, 0, 2'b00, 8'd0, 21'h0000F0, 0, 9'h100, 0));
    vecs.push_back(mkv(I_SW,   0, 0, 2'b00, 8'd0, 21'h000000, 0, 9'h084, 0));
    // BRANCH on cond[1]: taken, then not taken
    vecs.push_back(mkv(I_BEQ,  1, 0, 2'b10, 8'd0, 21'h000777, 1, 9'h180, 0));
    vecs.push_back(mkv(I_BEQ,  1, 0, 2'b10, 8'd0, 21'h000055, 0, 9'h005, 0));
    vecs.push_back(mkv(I_BEQ,  1, 0, 2'b01, 8'd0, 21'h000777, 0, 9'h180, 0));
    vecs.push_back(mkv(I_BEQ,  0, 0, 2'b01, 8'd0, 21'h000000, 0, 9'h180, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      instruction = vecs[i].instr; instr_valid = vecs[i].vld; stall = vecs[i].stl;
      cond = vecs[i].cnd; cnt_load = vecs[i].cl;
      #1 chk_all($sformatf("v%0d", i), vecs[i].ctrl, vecs[i].bsy, vecs[i].upc, vecs[i].ill);
    end
    stall = 1'b0; cond = '0;

    // reset mid-sequence clears valid bits and aborts the loop
    @(negedge clk);
    instruction = I_SW; instr_valid = 1'b1; cnt_load = 8'd3;
    #1 chk("rst_pre busy", 32'(busy), 32'd1);
    @(negedge clk);
    #1 chk("rst_pre upc", 32'(upc), 32'h100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; instruction = '0; instr_valid = 1'b0;
    #1 chk_all("rst_post", 21'h0, 1'b0, 9'h000, 1'b0);
    @(negedge clk);
    instruction = I_ADD; instr_valid = 1'b1;
    #1 chk_all("rst_add", 21'h0, 1'b0, 9'h0C0, 1'b1);
    ld(9'h0C0, 21'h1E0000, DISPATCH, 1'b0, 9'h000);
    #1 chk_all("reload_add", 21'h1E0000, 1'b0, 9'h0C0, 1'b0);

    // write to the entry being dispatched: old data this cycle, new next
    @(negedge clk);
    ucode_we = 1'b1; ucode_waddr = 9'h0C0; ucode_wdata = {21'h0ABCDE, 3'b000, 1'b0, 9'h000};
    #1 chk("wcoll old ctrl", 32'(ctrl_signals), 32'h1E0000);
    @(negedge clk);
    ucode_we = 1'b0;
    #1 chk("wcoll new ctrl", 32'(ctrl_signals), 32'h0ABCDE);

    @(negedge clk);
    instruction = '0; instr_valid = 1'b1;
    #1 chk("zero ctrl", 32'(ctrl_signals), 32'h0);
    chk("zero busy", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
